crank_wheel_gen: RTL and testbench

Synthesizable crank-wheel signal generator that emits a 60-2 style toothed-wheel waveform. It is the transmit-side counterpart of the angle generator's capture/gap-search front end. It is used on-board as a bench stimulus and as a limp-home synthetic crank source, driving the same input the VR filter samples. Tooth period is programmable in clock cycles and updates only at tooth boundaries, so every tooth is glitch-free.

---
 rtl/crank_wheel_gen_pkg.sv | 20 ++
 rtl/crank_phase_cnt.sv | 49 ++++
 rtl/crank_wheel_gen.sv | 143 ++++++++++++++
 tb/tb_crank_wheel_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crank_wheel_gen_pkg.sv
// Shared types and constants for the crank-wheel generator.
// The optional cam output is built only when CRANK_WHEEL_GEN_CAM_EN is defined.
package crank_wheel_gen_pkg;

    // Generator state: stopped, driving a real tooth, or in a missing-tooth slot
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TOOTH = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int MIN_PERIOD_DEF  = 4;
    localparam int TOOTH_NUM_WIDTH = 8;

    // First tooth position that belongs to the gap
    function automatic int gap_start(input int total, input int missing);
        return total - missing;
    endfunction

endpackage

// File: rtl/crank_phase_cnt.sv
// Phase counter for one tooth position: holds the period shadow (loaded with
// clamping at tooth boundaries), flags the last phase of the position and
// provides the next-cycle high-half compare so the waveform can be registered.
module crank_phase_cnt #(
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    adv_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    term_o,
    output logic                    high_d_o
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE   = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
    logic [PERIOD_WIDTH-1:0] shadow_q, shadow_d;

    // Next phase/shadow: a load restarts the position with a clamped period
    always_comb begin
        phase_d  = phase_q;
        shadow_d = shadow_q;
        if (load_i) begin
            phase_d  = '0;
            shadow_d = (period_i < MIN_P) ? MIN_P : period_i;
        end else if (adv_i) begin
            phase_d = phase_q + ONE;
        end
    end

    // Phase and shadow registers; shadow rests at the minimum period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            shadow_q <= MIN_P;
        end else begin
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
        end
    end

    assign term_o   = (phase_q == (shadow_q - ONE));
    assign high_d_o = (phase_d < (shadow_d >> 1));

endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 style crank-wheel waveform generator. Tooth period is sampled only at
// tooth boundaries so every tooth is whole. All outputs come from flops.
// Optional cam phase output: define CRANK_WHEEL_GEN_CAM_EN.
module crank_wheel_gen
    import crank_wheel_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH  = 24,
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int MIN_PERIOD    = MIN_PERIOD_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [PERIOD_WIDTH-1:0]    period,
    output logic                       crank_out,
    output logic [TOOTH_NUM_WIDTH-1:0] tooth_num,
    output logic                       sync_pulse,
    output logic                       running,
    output logic                       cam_out
);

    localparam logic [PERIOD_WIDTH-1:0]    MIN_P      = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [TOOTH_NUM_WIDTH-1:0] LAST_TOOTH = TOOTH_NUM_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [TOOTH_NUM_WIDTH-1:0] GAP_TOOTH  =
        TOOTH_NUM_WIDTH'(gap_start(TEETH_TOTAL, TEETH_MISSING));
    localparam logic [TOOTH_NUM_WIDTH-1:0] ONE8       = TOOTH_NUM_WIDTH'(1);

    state_e                       state_q, state_d;
    logic [TOOTH_NUM_WIDTH-1:0]   tooth_q, tooth_d, tooth_nxt;
    logic                         crank_q, crank_d;
    logic                         sync_q, sync_d;
    logic                         running_q, running_d;
    logic                         load, adv, term, high_d;

    crank_phase_cnt #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst),
        .load_i   (load),
        .adv_i    (adv),
        .period_i (period),
        .term_o   (term),
        .high_d_o (high_d)
    );

    assign tooth_nxt = (tooth_q == LAST_TOOTH) ? '0 : tooth_q + ONE8;

    // FSM next state: start from IDLE, advance or stop only at tooth boundaries
    always_comb begin
        state_d = state_q;
        tooth_d = tooth_q;
        sync_d  = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ena && (period >= MIN_P)) begin
                    state_d = TOOTH;
                    tooth_d = '0;
                    load    = 1'b1;
                    sync_d  = 1'b1;
                end
            end
            TOOTH, GAP: begin
                if (term) begin
                    load = 1'b1;
                    if (ena) begin
                        tooth_d = tooth_nxt;
                        sync_d  = (tooth_nxt == '0);
                        state_d = (tooth_nxt >= GAP_TOOTH) ? GAP : TOOTH;
                    end else begin
                        state_d = IDLE;
                        tooth_d = '0;
                    end
                end else begin
                    adv = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        crank_d   = (state_d == TOOTH) && high_d;
        running_d = (state_d != IDLE);
    end

    // State and output registers; reset forces everything low immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tooth_q   <= '0;
            crank_q   <= 1'b0;
            sync_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tooth_q   <= tooth_d;
            crank_q   <= crank_d;
            sync_q    <= sync_d;
            running_q <= running_d;
        end
    end

    assign crank_out  = crank_q;
    assign tooth_num  = tooth_q;
    assign sync_pulse = sync_q;
    assign running    = running_q;

`ifdef CRANK_WHEEL_GEN_CAM_EN
    localparam logic [TOOTH_NUM_WIDTH-1:0] HALF_TOOTH = TOOTH_NUM_WIDTH'(TEETH_TOTAL / 2);

    logic rev_q, rev_d, cam_q, cam_d, wrap;

    // Revolution parity: cleared on start/stop, toggled at each wrap to tooth 0
    always_comb begin
        wrap  = (state_q != IDLE) && term && ena && (tooth_nxt == '0);
        rev_d = rev_q;
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            rev_d = 1'b0;
        end else if (wrap) begin
            rev_d = ~rev_q;
        end
        cam_d = (state_d != IDLE) && !rev_d && (tooth_d < HALF_TOOTH);
    end

    // Cam registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_q <= 1'b0;
            cam_q <= 1'b0;
        end else begin
            rev_q <= rev_d;
            cam_q <= cam_d;
        end
    end

    assign cam_out = cam_q;
`else
    assign cam_out = 1'b0;
`endif

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: tooth-level reference model checked every cycle,
// a table of constant-period revolution measurements, and hand-written
// sequences for period change, stop/restart, async reset and cam phase.
module tb_crank_wheel_gen;

    localparam int P_MIN   = 4;
    localparam int TOTAL   = 60;
    localparam int MISSING = 2;
`ifdef CRANK_WHEEL_GEN_CAM_EN
    localparam int EXP_CAM_HI = 240;
`else
    localparam int EXP_CAM_HI = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [23:0] period = 24'd0;
    logic        crank_out, sync_pulse, running, cam_out;
    logic [7:0]  tooth_num;
    logic [11:0] dut_out;

    crank_wheel_gen dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .period     (period),
        .crank_out  (crank_out),
        .tooth_num  (tooth_num),
        .sync_pulse (sync_pulse),
        .running    (running),
        .cam_out    (cam_out)
    );

    assign dut_out = {crank_out, sync_pulse, running, cam_out, tooth_num};

    // clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: expected outputs for the remaining cycles of the tooth
    logic [11:0] exp_q[$];
    logic [11:0] cur = '0;
    bit          m_run = 1'b0;
    int          m_tooth = 0;
    bit          m_rev = 1'b0;

    typedef struct {
        int period;
        bit exp_start;
        int exp_rev;
        int exp_rises;
        int exp_high;
        int exp_gap_low;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cam_exp(input int k);
`ifdef CRANK_WHEEL_GEN_CAM_EN
        return !m_rev && (k < TOTAL / 2);
`else
        return (k < 0);
`endif
    endfunction

    // one full tooth position of period p as a list of per-cycle outputs
    task automatic push_tooth(input int k, input int p);
        logic [11:0] v;
        for (int i = 0; i < p; i++) begin
            v[11]  = (k < TOTAL - MISSING) && (i < p / 2);
            v[10]  = (k == 0) && (i == 0);
            v[9]   = 1'b1;
            v[8]   = cam_exp(k);
            v[7:0] = 8'(k);
            exp_q.push_back(v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run   = 1'b0;
        m_tooth = 0;
        m_rev   = 1'b0;
        cur     = '0;
    endtask

    task automatic model_edge(input bit e, input int p);
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            if (m_run && e) begin
                m_tooth = (m_tooth + 1) % TOTAL;
                if (m_tooth == 0) m_rev = ~m_rev;
                push_tooth(m_tooth, (p < P_MIN) ? P_MIN : p);
            end else if (!m_run && e && (p >= P_MIN)) begin
                m_run   = 1'b1;
                m_tooth = 0;
                m_rev   = 1'b0;
                push_tooth(0, p);
            end else begin
                m_run = 1'b0;
            end
            cur = m_run ? exp_q.pop_front() : 12'h000;
        end
    endtask

    // driver: one clock, model step on the edge, compare 1 time unit later
    task automatic tick();
        bit e;
        int p;
        e = ena;
        p = int'(period);
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(e, p);
        #1;
        chk("model_cycle", 32'(dut_out), 32'(cur));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ena = 1'b0;
        #1;
        chk("reset_outputs", 32'(dut_out), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_tooth(input int k);
        int n;
        n = 0;
        while (int'(tooth_num) != k && n < 2000) begin
            tick();
            n++;
        end
        chk("wait_tooth_reached", 32'(tooth_num), 32'(k));
    endtask

    task automatic wait_sync(output bit seen);
        int n;
        n = 0;
        while (!sync_pulse && n < 20) begin
            tick();
            n++;
        end
        seen = sync_pulse;
    endtask

    task automatic measure_tooth(output int len, output int hi);
        int t;
        t   = int'(tooth_num);
        len = 0;
        hi  = 0;
        while (int'(tooth_num) == t && len < 200) begin
            len++;
            hi += int'(crank_out);
            tick();
        end
    endtask

    // starting on a sync cycle, runs to the next sync and measures the wheel
    task automatic measure_rev(output int clocks, output int rises, output int high,
                               output int maxlow);
        bit prev;
        int low;
        prev = 1'b0; low = 0;
        clocks = 0; rises = 0; high = 0; maxlow = 0;
        do begin
            clocks++;
            if (crank_out && !prev) rises++;
            if (crank_out) begin
                high++;
                low = 0;
            end else begin
                low++;
                if (low > maxlow) maxlow = low;
            end
            prev = crank_out;
            tick();
        end while (!sync_pulse && clocks < 2000);
    endtask

    initial begin
        bit seen;
        int clocks, rises, high, maxlow, len, hi, cam_hi;

        vecs[0] = '{period: 8, exp_start: 1'b1, exp_rev: 480, exp_rises: 58, exp_high: 232, exp_gap_low: 20};
        vecs[1] = '{period: 5, exp_start: 1'b1, exp_rev: 300, exp_rises: 58, exp_high: 116, exp_gap_low: 13};
        vecs[2] = '{period: 4, exp_start: 1'b1, exp_rev: 240, exp_rises: 58, exp_high: 116, exp_gap_low: 10};
        vecs[3] = '{period: 3, exp_start: 1'b0, exp_rev: 0,   exp_rises: 0,  exp_high: 0,   exp_gap_low: 0};

        // reset, then idle with ena low and with a too-short period
        #2;
        do_reset();
        repeat (100) tick();
        chk("idle_running", 32'(running), 32'd0);
        period = 24'd2;
        ena = 1'b1;
        repeat (20) tick();
        chk("short_period_idle", 32'(running), 32'd0);

        // constant-period revolutions
        for (int v = 0; v < 4; v++) begin
            do_reset();
            period = 24'(vecs[v].period);
            ena = 1'b1;
            wait_sync(seen);
            chk("start_seen", 32'(seen), 32'(vecs[v].exp_start));
            if (seen) begin
                measure_rev(clocks, rises, high, maxlow);
                chk("rev_clocks", 32'(clocks), 32'(vecs[v].exp_rev));
                chk("rev_rises", 32'(rises), 32'(vecs[v].exp_rises));
                chk("rev_high", 32'(high), 32'(vecs[v].exp_high));
                chk("gap_low", 32'(maxlow), 32'(vecs[v].exp_gap_low));
                chk("sync_crank", 32'(crank_out), 32'd1);
                chk("sync_tooth", 32'(tooth_num), 32'd0);
            end
        end

        // period change mid-tooth, then clamp below minimum
        do_reset();
        period = 24'd8;
        ena = 1'b1;
        wait_tooth(10);
        tick();
        tick();
        period = 24'd12;
        measure_tooth(len, hi);
        chk("tooth10_len", 32'(len + 2), 32'd8);
        measure_tooth(len, hi);
        chk("tooth11_len", 32'(len), 32'd12);
        chk("tooth11_high", 32'(hi), 32'd6);
        period = 24'd3;
        measure_tooth(len, hi);
        chk("tooth12_len", 32'(len), 32'd12);
        measure_tooth(len, hi);
        chk("clamp_len", 32'(len), 32'd4);
        chk("clamp_high", 32'(hi), 32'd2);

        // stop at the end of tooth 20, then restart
        period = 24'd8;
        wait_tooth(20);
        tick();
        tick();
        ena = 1'b0;
        measure_tooth(len, hi);
        chk("stop_tooth_len", 32'(len + 2), 32'd8);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_crank", 32'(crank_out), 32'd0);
        repeat (5) tick();
        ena = 1'b1;
        tick();
        chk("restart_sync", 32'(sync_pulse), 32'd1);
        chk("restart_tooth", 32'(tooth_num), 32'd0);
        chk("restart_crank", 32'(crank_out), 32'd1);

        // asynchronous reset in the middle of tooth 30
        wait_tooth(30);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_out), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;

        // cam phase over two revolutions
        do_reset();
        period = 24'd8;
        ena = 1'b1;
        wait_sync(seen);
        chk("cam_start_seen", 32'(seen), 32'd1);
        cam_hi = 0;
        repeat (960) begin
            cam_hi += int'(cam_out);
            tick();
        end
        chk("cam_high_cycles", 32'(cam_hi), 32'(EXP_CAM_HI));
        chk("cam_period_sync", 32'(sync_pulse), 32'd1);

        // randomized period/enable traffic with occasional resets
        do_reset();
        period = 24'd6;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 4) period = 24'($urandom_range(2, 12));
            ena = ($urandom_range(0, 99) < 98);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
